prime_seq_ctrl: RTL

Sequential controller for primality testing. It accepts one WIDTH-bit operand per valid/ready handshake and runs trial division with divisors d = 2, 3, 4, … while d*d <= n. Each trial remainder comes from a shared bit-serial restoring divider that the controller sequences. The result (prime flag and smallest factor) is returned on a valid/ready output port. It replaces the combinational checker where timing or area rule out an unrolled modulo tree.

---
 rtl/prime_seq_if.sv | 26 ++
 rtl/prime_seq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/prime_seq_if.sv
// Handshake bundle between an operand producer / result consumer and the
// sequential primality controller.
interface prime_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_prime;
    logic [WIDTH-1:0] out_factor;
    logic             busy;

    // Controller side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_prime, out_factor, busy
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_prime, out_factor, busy
    );
endinterface

// File: rtl/prime_seq_ctrl.sv
// Sequential primality tester: trial division by d = 2, 3, ... while
// d*d <= n, each remainder produced by a bit-serial restoring divider
// (one quotient bit per cycle, MSB first).
module prime_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    prime_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        EVAL,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prime_q, prime_d;
    logic [WIDTH-1:0] factor_q, factor_d;

    // Divisor square at full double width so the bound test never wraps.
    logic [2*WIDTH-1:0] d_ext;
    logic [2*WIDTH-1:0] n_ext;
    logic [2*WIDTH-1:0] d_sq;
    // One restoring-division step: shift in the next dividend bit.
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     d_w;
    logic [WIDTH:0]     t_sub;
    logic               t_ge;

    assign d_ext = {{WIDTH{1'b0}}, d_q};
    assign n_ext = {{WIDTH{1'b0}}, n_q};
    assign d_sq  = d_ext * d_ext;
    assign t     = {rem_q, n_q[cnt_q]};
    assign d_w   = {1'b0, d_q};
    assign t_sub = t - d_w;
    assign t_ge  = (t >= d_w);

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_prime  = prime_q;
    assign bus.out_factor = factor_q;

    // State and datapath registers; reset abandons any test in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            d_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            prime_q  <= 1'b0;
            factor_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            prime_q  <= prime_d;
            factor_q <= factor_d;
        end
    end

    // Next-state and datapath updates for the trial-division sequence.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        d_d      = d_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        prime_d  = prime_q;
        factor_d = factor_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    n_d     = bus.in_data;
                    d_d     = WIDTH'(2);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n_q < WIDTH'(2)) begin
                    prime_d  = 1'b0;
                    factor_d = '0;
                    state_d  = DONE;
                end else if (d_sq > n_ext) begin
                    prime_d  = 1'b1;
                    factor_d = '0;
                    state_d  = DONE;
                end else begin
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = DIV;
                end
            end
            DIV: begin
                // t < 2d, so the restored remainder always fits WIDTH bits.
                rem_d = t_ge ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            EVAL: begin
                if (rem_q == '0) begin
                    prime_d  = 1'b0;
                    factor_d = d_q;
                    state_d  = DONE;
                end else begin
                    d_d     = d_q + WIDTH'(1);
                    state_d = CHECK;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
